safe_cracker: RTL and testbench
===============================

Name: safe_cracker

Overview:
Brute-force PIN transmitter for the digit-serial safe lock interface (din/din_valid in, unlocked out).
- Walks every candidate code from 0 to all-ones.
- For each candidate: resets the safe, sends the digits one per valid pulse, then samples unlocked.
- Stops on the first code that unlocks (reports it) or after the last candidate (reports exhaustion).
- Sits beside the lock on the verification/demo top as its driver.

Parameters:
- NDIGITS, 4: digits per code.
- DIGIT_W, 4: bits per digit.
- GAP, 0: idle cycles (din_valid=0) inserted between consecutive digits; none after the last digit.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a search; ignored while busy.
- safe_reset  out  1  reset to the lock.
- din  out  DIGIT_W  digit to the lock.
- din_valid  out  1  digit strobe, one cycle per digit.
- unlocked  in  1  lock status.
- busy  out  1  search in progress.
- found  out  1  sticky: search ended with unlock.
- exhausted  out  1  sticky: all candidates failed.
- code  out  NDIGITS*DIGIT_W  winning code, valid when found=1.

Behaviour:
- Reset values: safe_reset=1 while reset is high (combinational OR with the FSM value), otherwise 0. din=0, din_valid=0, busy=0, found=0, exhausted=0, code=0, FSM=IDLE, candidate=0.
- All outputs except safe_reset are registered.
- IDLE: on start=1 → clear found/exhausted, set candidate=0, busy=1, go to CLEAR.
- CLEAR (1 cycle): safe_reset=1, digit index=0 → SEND.
- SEND: din = digit[index] of the candidate, most-significant digit first (digit 0 = bits [N*W-1 -: W]); din_valid=1 for exactly one cycle.
  - If index=NDIGITS-1 → CHECK.
  - Else → GAPW when GAP>0, otherwise stay in SEND with index+1.
- GAPW: din_valid=0 for GAP cycles, then SEND with index+1.
- CHECK (1 cycle, the cycle after the last digit strobe): sample unlocked.
  - unlocked=1 → code=candidate, found=1 → DONE.
  - unlocked=0 and candidate=all-ones → exhausted=1 → DONE.
  - Otherwise candidate+1 → CLEAR.
- DONE: busy=0, found/exhausted/code held. A new start re-enters the search exactly as from IDLE.
- din holds its last value when din_valid=0. safe_reset=0 in every state except CLEAR.
- Attempt length L = 2 + NDIGITS + (NDIGITS-1)*GAP cycles.
- Result of attempt k (0-based) is visible on found/exhausted at cycle 1 + L*(k+1), where the start edge is cycle 0.
- Candidate counter is NDIGITS*DIGIT_W bits. The all-ones check precedes the increment, so it never wraps.
- start while busy: ignored, no restart.
- reset mid-search: immediate return to IDLE with reset values; the lock is reset via safe_reset.
- unlocked is ignored outside CHECK, including during CLEAR/SEND.

Optional Feature:
- Macro: SAFE_CRACKER_ATTEMPTS_EN.
- When defined: adds output attempts [31:0].
  - Cleared to 0 on reset and on an accepted start.
  - Incremented by 1 in every CHECK cycle, saturating at 0xFFFFFFFF.
  - Holds in DONE. On found it equals candidate+1.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Defaults, lock code 0xC0DE, start at cycle 0 → busy=1 at cycle 1. Sequence per attempt: safe_reset, then 4 din_valid pulses, then CHECK. found=1 and code=0xC0DE at cycle 296251; busy=0; attempts=49375 when the macro is on.
- Lock code 0x0000 → first attempt sends digits 0,0,0,0; found=1, code=0 at cycle 7; exhausted=0.
- NDIGITS=2, unlocked tied 0 → 256 attempts; exhausted=1, found=0 at cycle 1025; no candidate wrap, din_valid never asserted after DONE.
- GAP=2, lock code 0xC0DE → exactly 2 idle cycles between strobes and none after the last; L=12; found=1 at cycle 1+12*49375=592501.
- reset high for 1 cycle mid-attempt (cycle 500) → all outputs at reset values next cycle, safe_reset=1 during reset. Subsequent start restarts from candidate 0 and finds 0xC0DE at start+296251.
- start pulses while busy and unlocked pulses during SEND → no restart, no false found; result timing unchanged.

Source files
------------

// File: rtl/safe_cracker.sv
// Brute-force PIN driver for the digit-serial safe lock: walks candidates 0..all-ones.
// Optional attempt counter output enabled by defining SAFE_CRACKER_ATTEMPTS_EN.
module safe_cracker #(
    parameter int NDIGITS = 4,
    parameter int DIGIT_W = 4,
    parameter int GAP     = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic                         safe_reset,
    output logic [DIGIT_W-1:0]           din,
    output logic                         din_valid,
    input  logic                         unlocked,
    output logic                         busy,
    output logic                         found,
    output logic                         exhausted,
    output logic [NDIGITS*DIGIT_W-1:0]   code
`ifdef SAFE_CRACKER_ATTEMPTS_EN
    ,
    output logic [31:0]                  attempts
`endif
);

    localparam int CW = NDIGITS * DIGIT_W;
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [2:0] {IDLE, CLEAR, SEND, GAPW, CHECK, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cand;
    logic [IW-1:0]   idx;
    logic [GW-1:0]   gcnt;

    // Digit 0 is the most-significant digit of the candidate.
    function automatic logic [DIGIT_W-1:0] digit_of(input logic [CW-1:0] c, input logic [IW-1:0] i);
        logic [CW-1:0] sh;
        sh = c >> (DIGIT_W * (NDIGITS - 1 - int'(i)));
        return sh[DIGIT_W-1:0];
    endfunction

    assign safe_reset = reset | (state == CLEAR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cand      <= '0;
            idx       <= '0;
            gcnt      <= '0;
            din       <= '0;
            din_valid <= 1'b0;
            busy      <= 1'b0;
            found     <= 1'b0;
            exhausted <= 1'b0;
            code      <= '0;
`ifdef SAFE_CRACKER_ATTEMPTS_EN
            attempts  <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        found     <= 1'b0;
                        exhausted <= 1'b0;
                        cand      <= '0;
                        busy      <= 1'b1;
                        state     <= CLEAR;
`ifdef SAFE_CRACKER_ATTEMPTS_EN
                        attempts  <= '0;
`endif
                    end
                end
                // Outputs are registered, so each strobe is loaded on entry to SEND.
                CLEAR: begin
                    idx       <= '0;
                    din       <= digit_of(cand, '0);
                    din_valid <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (idx == IW'(NDIGITS - 1)) begin
                        din_valid <= 1'b0;
                        state     <= CHECK;
                    end else if (GAP > 0) begin
                        din_valid <= 1'b0;
                        gcnt      <= '0;
                        state     <= GAPW;
                    end else begin
                        idx       <= idx + 1'b1;
                        din       <= digit_of(cand, idx + 1'b1);
                        din_valid <= 1'b1;
                    end
                end
                GAPW: begin
                    if (gcnt == GW'(GAP - 1)) begin
                        idx       <= idx + 1'b1;
                        din       <= digit_of(cand, idx + 1'b1);
                        din_valid <= 1'b1;
                        state     <= SEND;
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
                CHECK: begin
`ifdef SAFE_CRACKER_ATTEMPTS_EN
                    if (attempts != '1) attempts <= attempts + 1'b1;
`endif
                    if (unlocked) begin
                        code  <= cand;
                        found <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else if (cand == '1) begin
                        exhausted <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end else begin
                        cand  <= cand + 1'b1;
                        state <= CLEAR;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_safe_cracker.sv
// Self-checking bench for safe_cracker: two instances (4x4 no gap, 2x4 with GAP=2) driving behavioural locks.
module tb_safe_cracker;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_d = 1'b0, start_g = 1'b0;

    logic        sr_d, dv_d, unl_d, busy_d, found_d, exh_d;
    logic [3:0]  din_d;
    logic [15:0] code_d;
    logic        sr_g, dv_g, unl_g, busy_g, found_g, exh_g;
    logic [3:0]  din_g;
    logic [7:0]  code_g;
`ifdef SAFE_CRACKER_ATTEMPTS_EN
    logic [31:0] att_d, att_g;
`endif

    int compared = 0;
    int mismatched = 0;

    logic [15:0] secret_d = '0;
    logic [7:0]  secret_g = '0;
    bit len_d = 1'b1, len_g = 1'b1, noise_en = 1'b0, noise_bit = 1'b0;
    int lcnt_d = 0, lcnt_g = 0;
    logic [15:0] lbuf_d = '0;
    logic [7:0]  lbuf_g = '0;

    safe_cracker dut_d (
        .clk(clk), .reset(reset), .start(start_d), .safe_reset(sr_d), .din(din_d),
        .din_valid(dv_d), .unlocked(unl_d), .busy(busy_d), .found(found_d),
        .exhausted(exh_d), .code(code_d)
`ifdef SAFE_CRACKER_ATTEMPTS_EN
        , .attempts(att_d)
`endif
    );

    safe_cracker #(.NDIGITS(2), .DIGIT_W(4), .GAP(2)) dut_g (
        .clk(clk), .reset(reset), .start(start_g), .safe_reset(sr_g), .din(din_g),
        .din_valid(dv_g), .unlocked(unl_g), .busy(busy_g), .found(found_g),
        .exhausted(exh_g), .code(code_g)
`ifdef SAFE_CRACKER_ATTEMPTS_EN
        , .attempts(att_g)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) noise_bit <= 1'($urandom_range(0, 1));

    // Behavioural locks: collect digits since the last lock reset, open on an exact match.
    always @(posedge clk) begin
        if (sr_d) begin
            lcnt_d <= 0;
            lbuf_d <= '0;
        end else if (dv_d) begin
            lcnt_d <= lcnt_d + 1;
            lbuf_d <= {lbuf_d[11:0], din_d};
        end
    end
    always @(posedge clk) begin
        if (sr_g) begin
            lcnt_g <= 0;
            lbuf_g <= '0;
        end else if (dv_g) begin
            lcnt_g <= lcnt_g + 1;
            lbuf_g <= {lbuf_g[3:0], din_g};
        end
    end
    assign unl_d = (len_d && lcnt_d == 4 && lbuf_d == secret_d) || (noise_en && noise_bit && dv_d);
    assign unl_g = (len_g && lcnt_g == 2 && lbuf_g == secret_g) || (noise_en && noise_bit && dv_g);

    task automatic run(input bit g, input bit noisy, input int budget, output int n);
        bit fin;
        n = 0;
        fin = 1'b0;
        if (g) start_g = 1'b1; else start_d = 1'b1;
        while (!fin && n < budget) begin
            @(posedge clk); #1;
            n++;
            if (noisy) begin
                if (g) start_g = ($urandom_range(0, 3) == 0);
                else   start_d = ($urandom_range(0, 3) == 0);
            end else begin
                start_g = 1'b0;
                start_d = 1'b0;
            end
            fin = (n > 1) && (g ? (found_g | exh_g) : (found_d | exh_d));
        end
        start_g = 1'b0;
        start_d = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if ({busy_d, found_d, exh_d, dv_d, din_d, code_d} !== '0) begin
            mismatched++;
            $display("FAIL reset_d: got busy=%0b found=%0b exh=%0b dv=%0b din=%0h code=%0h expected all 0",
                     busy_d, found_d, exh_d, dv_d, din_d, code_d);
        end
        compared++;
        if ({busy_g, found_g, exh_g, dv_g, din_g, code_g} !== '0) begin
            mismatched++;
            $display("FAIL reset_g: got busy=%0b found=%0b exh=%0b dv=%0b din=%0h code=%0h expected all 0",
                     busy_g, found_g, exh_g, dv_g, din_g, code_g);
        end
        compared++;
        if (sr_d !== 1'b1 || sr_g !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_safe_reset: got %0b/%0b expected 1/1", sr_d, sr_g);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        compared++;
        if (sr_d !== 1'b0 || sr_g !== 1'b0) begin
            mismatched++;
            $display("FAIL idle_safe_reset: got %0b/%0b expected 0/0", sr_d, sr_g);
        end
    endtask

    task automatic test_zero_code();
        int n;
        secret_d = '0;
        len_d = 1'b1;
        run(1'b0, 1'b0, 200, n);
        compared++;
        if (n !== 7 || found_d !== 1'b1 || exh_d !== 1'b0 || code_d !== 16'h0000) begin
            mismatched++;
            $display("FAIL zero_code: got cycle=%0d found=%0b exh=%0b code=%0h expected 7/1/0/0", n, found_d, exh_d, code_d);
        end
`ifdef SAFE_CRACKER_ATTEMPTS_EN
        compared++;
        if (att_d !== 32'd1) begin
            mismatched++;
            $display("FAIL zero_attempts: got %0d expected 1", att_d);
        end
`endif
    endtask

    task automatic test_find_noisy();
        int n;
        noise_en = 1'b1;
        for (int r = 0; r < 3; r++) begin
            secret_d = 16'($urandom_range(1, 255));
            run(1'b0, 1'b1, 3000, n);
            compared++;
            if (n !== 1 + 6 * (int'(secret_d) + 1)) begin
                mismatched++;
                $display("FAIL find_cycle: got %0d expected %0d", n, 1 + 6 * (int'(secret_d) + 1));
            end
            compared++;
            if (found_d !== 1'b1 || exh_d !== 1'b0 || busy_d !== 1'b0 || code_d !== secret_d) begin
                mismatched++;
                $display("FAIL find_result: got found=%0b exh=%0b busy=%0b code=%0h expected 1/0/0/%0h",
                         found_d, exh_d, busy_d, code_d, secret_d);
            end
`ifdef SAFE_CRACKER_ATTEMPTS_EN
            compared++;
            if (att_d !== 32'(secret_d) + 32'd1) begin
                mismatched++;
                $display("FAIL find_attempts: got %0d expected %0d", att_d, int'(secret_d) + 1);
            end
`endif
        end
        noise_en = 1'b0;
    endtask

    task automatic test_gap();
        int n, k, j, d, exp_din;
        bit exp_v, fin;
        localparam int L = 6;
        secret_g = 8'($urandom_range(2, 255));
        len_g = 1'b1;
        n = 0;
        fin = 1'b0;
        start_g = 1'b1;
        while (!fin && n < 3000) begin
            @(posedge clk); #1;
            n++;
            start_g = 1'b0;
            if (n <= 2 * L) begin
                k = (n - 1) / L;
                j = (n - 1) % L;
                exp_v = (j >= 1) && (j <= L - 2) && ((j - 1) % 3 == 0);
                compared++;
                if (sr_g !== (j == 0) || dv_g !== exp_v) begin
                    mismatched++;
                    $display("FAIL gap_pattern: cycle %0d got sr=%0b dv=%0b expected %0b/%0b", n, sr_g, dv_g, (j == 0), exp_v);
                end
                if (exp_v) begin
                    d = (j - 1) / 3;
                    exp_din = (k >> (4 * (1 - d))) & 15;
                    compared++;
                    if (din_g !== 4'(exp_din)) begin
                        mismatched++;
                        $display("FAIL gap_digit: cycle %0d got %0h expected %0h", n, din_g, exp_din);
                    end
                end
            end
            fin = (n > 1) && (found_g | exh_g);
        end
        compared++;
        if (n !== 1 + L * (int'(secret_g) + 1) || found_g !== 1'b1 || code_g !== secret_g) begin
            mismatched++;
            $display("FAIL gap_find: got cycle=%0d found=%0b code=%0h expected %0d/1/%0h",
                     n, found_g, code_g, 1 + L * (int'(secret_g) + 1), secret_g);
        end
    endtask

    task automatic test_exhaust();
        int n;
        bit any_dv;
        len_g = 1'b0;
        run(1'b1, 1'b0, 3000, n);
        compared++;
        if (n !== 1537 || exh_g !== 1'b1 || found_g !== 1'b0 || busy_g !== 1'b0) begin
            mismatched++;
            $display("FAIL exhaust: got cycle=%0d exh=%0b found=%0b busy=%0b expected 1537/1/0/0", n, exh_g, found_g, busy_g);
        end
`ifdef SAFE_CRACKER_ATTEMPTS_EN
        compared++;
        if (att_g !== 32'd256) begin
            mismatched++;
            $display("FAIL exhaust_attempts: got %0d expected 256", att_g);
        end
`endif
        any_dv = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            any_dv = any_dv | dv_g | busy_g | sr_g;
        end
        compared++;
        if (any_dv !== 1'b0 || exh_g !== 1'b1) begin
            mismatched++;
            $display("FAIL exhaust_quiet: got activity=%0b exh=%0b expected 0/1", any_dv, exh_g);
        end
        len_g = 1'b1;
    endtask

    task automatic test_reset_mid();
        int n;
        secret_d = 16'($urandom_range(100, 255));
        start_d = 1'b1;
        repeat (50) begin
            @(posedge clk); #1;
            start_d = 1'b0;
        end
        reset = 1'b1;
        #1;
        compared++;
        if (sr_d !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_mid_comb: got safe_reset=%0b expected 1", sr_d);
        end
        @(posedge clk); #1;
        compared++;
        if ({busy_d, found_d, exh_d, dv_d, din_d, code_d} !== '0 || sr_d !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_mid_vals: got busy=%0b found=%0b dv=%0b din=%0h code=%0h sr=%0b expected 0s, sr=1",
                     busy_d, found_d, dv_d, din_d, code_d, sr_d);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        noise_en = 1'b1;
        run(1'b0, 1'b1, 3000, n);
        noise_en = 1'b0;
        compared++;
        if (n !== 1 + 6 * (int'(secret_d) + 1) || found_d !== 1'b1 || code_d !== secret_d) begin
            mismatched++;
            $display("FAIL reset_restart: got cycle=%0d found=%0b code=%0h expected %0d/1/%0h",
                     n, found_d, code_d, 1 + 6 * (int'(secret_d) + 1), secret_d);
        end
    endtask

    task automatic test_restart_from_done();
        int n;
        bit fin;
        secret_d = 16'($urandom_range(1, 100));
        start_d = 1'b1;
        @(posedge clk); #1;
        start_d = 1'b0;
        compared++;
        if (found_d !== 1'b0 || busy_d !== 1'b1 || exh_d !== 1'b0) begin
            mismatched++;
            $display("FAIL restart_clear: got found=%0b busy=%0b exh=%0b expected 0/1/0", found_d, busy_d, exh_d);
        end
        n = 1;
        fin = 1'b0;
        while (!fin && n < 3000) begin
            @(posedge clk); #1;
            n++;
            fin = found_d | exh_d;
        end
        compared++;
        if (n !== 1 + 6 * (int'(secret_d) + 1) || code_d !== secret_d) begin
            mismatched++;
            $display("FAIL restart_find: got cycle=%0d code=%0h expected %0d/%0h",
                     n, code_d, 1 + 6 * (int'(secret_d) + 1), secret_d);
        end
    endtask

    initial begin
        test_reset();
        test_zero_code();
        test_find_noisy();
        test_gap();
        test_exhaust();
        test_reset_mid();
        test_restart_from_done();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
